// File: rtl/mult_hilo_ctrl_pkg.sv
// Shared EX-stage definitions for the MULTU sequencer: FSM encoding,
// funct codes of the HI/LO instructions and multiplier signal encodings.
package mult_hilo_ctrl_pkg;

  // Default operand width and iteration count (one iteration per operand bit).
  localparam int WIDTH_DEFAULT = 32;
  localparam int ITER_DEFAULT  = 32;

  // R-type funct codes of the instructions this block serves.
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;

  // Multiplier mode select: iterate, or copy accumulator to the product port.
  localparam logic SIG_MULT = 1'b1;
  localparam logic SIG_OUT  = 1'b0;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_COMMIT = 3'd4
  } mul_state_e;

  // A multiply is in flight in every state except IDLE.
  function automatic logic state_busy(input mul_state_e s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/mult_hilo_ctrl.sv
// MULTU sequencer for the EX-stage shift-add multiplier. Loads operands,
// drives exactly ITER MULT cycles, drains the product, commits it to HI/LO,
// and stalls the pipeline for MFHI/MFLO/MULTU while a multiply is in flight.
// All multiplier controls are registered; the multiplier samples them on
// the falling edge, half a cycle after they settle.
module mult_hilo_ctrl
  import mult_hilo_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int ITER  = ITER_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic               mfhi_req,
  input  logic               mflo_req,
  output logic               stall,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               mul_load,
  output logic               mul_signal,
  output logic [WIDTH-1:0]   mul_dataA,
  output logic [WIDTH-1:0]   mul_dataB,
  input  logic [2*WIDTH-1:0] mul_product
);

  // Iteration counter must hold 0..ITER-1.
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(ITER - 1);

  mul_state_e    state_r;
  mul_state_e    state_nxt_s;
  logic [CW-1:0] count_r;
  logic          accept_s;

  // A new MULTU is only taken while idle; otherwise it waits under stall.
  assign accept_s = (state_r == ST_IDLE) && start;

  assign busy  = state_busy(state_r);
  assign stall = busy & (start | mfhi_req | mflo_req);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state sequencing: IDLE -> LOAD -> RUN x ITER -> DRAIN -> COMMIT -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        if (count_r == LAST_ITER) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        state_nxt_s = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Iteration counter: cleared outside RUN, counts one per MULT cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {CW{1'b0}};
    end else if (state_r == ST_RUN) begin
      count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= {CW{1'b0}};
    end
  end

  // Multiplier controls registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_load   <= 1'b0;
      mul_signal <= SIG_OUT;
    end else begin
      mul_load   <= (state_nxt_s == ST_LOAD);
      mul_signal <= (state_nxt_s == ST_RUN) ? SIG_MULT : SIG_OUT;
    end
  end

  // Operand latch: captured on acceptance, held until the next acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_dataA <= {WIDTH{1'b0}};
      mul_dataB <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      mul_dataA <= src_a;
      mul_dataB <= src_b;
    end else begin
      mul_dataA <= mul_dataA;
      mul_dataB <= mul_dataB;
    end
  end

  // HI/LO commit and one-cycle done pulse on the edge leaving COMMIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi   <= {WIDTH{1'b0}};
      lo   <= {WIDTH{1'b0}};
      done <= 1'b0;
    end else if (state_r == ST_COMMIT) begin
      hi   <= mul_product[2*WIDTH-1:WIDTH];
      lo   <= mul_product[WIDTH-1:0];
      done <= 1'b1;
    end else begin
      hi   <= hi;
      lo   <= lo;
      done <= 1'b0;
    end
  end

endmodule
